// File: rtl/jtkcpu_pkg.sv
// Shared constants, opcode classifiers and FSM encoding for the KONAMI CPU
// branch sequencer.
package jtkcpu_pkg;

    localparam logic [7:0] OP_BSR      = 8'hAA;
    localparam logic [7:0] OP_LBSR     = 8'hAB;
    localparam logic [7:0] SHORT_LO0   = 8'h60;
    localparam logic [7:0] SHORT_HI0   = 8'h67;
    localparam logic [7:0] SHORT_LO1   = 8'h70;
    localparam logic [7:0] SHORT_HI1   = 8'h77;
    localparam logic [7:0] LONG_LO0    = 8'h68;
    localparam logic [7:0] LONG_HI0    = 8'h6F;
    localparam logic [7:0] LONG_LO1    = 8'h78;
    localparam logic [7:0] LONG_HI1    = 8'h7F;

    typedef enum logic [2:0] {
        StIdle,
        StOfsH,
        StOfsL,
        StPushL,
        StPushH,
        StUpdate
    } brseq_state_e;

    function automatic logic op_is_short(input logic [7:0] op);
        return (op >= SHORT_LO0 && op <= SHORT_HI0) ||
               (op >= SHORT_LO1 && op <= SHORT_HI1) || (op == OP_BSR);
    endfunction

    function automatic logic op_is_long(input logic [7:0] op);
        return (op >= LONG_LO0 && op <= LONG_HI0) ||
               (op >= LONG_LO1 && op <= LONG_HI1) || (op == OP_LBSR);
    endfunction

    function automatic logic op_is_sub(input logic [7:0] op);
        return (op == OP_BSR) || (op == OP_LBSR);
    endfunction

endpackage

// File: rtl/jtkcpu_brseq_addr.sv
// Address arithmetic for the branch sequencer: return address, branch target
// and stack pointer decrements, all modulo 2^AW.
module jtkcpu_brseq_addr #(
    parameter int unsigned AW = 16
) (
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] s,
    input  logic          is_long,
    input  logic          taken,
    input  logic [7:0]    ofs_hi,
    input  logic [7:0]    ofs_lo,
    output logic [AW-1:0] pc_p1,
    output logic [AW-1:0] ret,
    output logic [AW-1:0] target,
    output logic [AW-1:0] s_m1,
    output logic [AW-1:0] s_m2
);

    logic signed [15:0] ofs16;
    logic [AW-1:0]      ofs_ext;

    always_comb begin
        ofs16   = is_long ? {ofs_hi, ofs_lo} : {{8{ofs_lo[7]}}, ofs_lo};
        // Signed source makes the size cast sign-extend when AW > 16
        ofs_ext = AW'(ofs16);
        pc_p1   = pc + AW'(1);
        ret     = pc + (is_long ? AW'(2) : AW'(1));
        target  = taken ? ret + ofs_ext : ret;
        s_m1    = s - AW'(1);
        s_m2    = s - AW'(2);
    end

endmodule

// File: rtl/jtkcpu_brseq.sv
// Branch execution sequencer: fetches the relative offset, pushes the return
// address for BSR/LBSR and hands the new PC/S to the register file.
module jtkcpu_brseq
    import jtkcpu_pkg::*;
#(
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          start,
    input  logic [7:0]    op,
    input  logic          branch,
    input  logic [AW-1:0] pc_in,
    input  logic [AW-1:0] s_in,
    output logic [AW-1:0] addr,
    output logic          rd,
    output logic          wr,
    output logic [7:0]    dout,
    input  logic [7:0]    din,
    input  logic          mem_ok,
    output logic [AW-1:0] pc_out,
    output logic          pc_we,
    output logic [AW-1:0] s_out,
    output logic          s_we,
    output logic          busy,
    output logic          done,
    output logic          err
);

    brseq_state_e  state_q;
    logic [AW-1:0] pc_q, s_q;
    logic          is_long_q, is_sub_q, taken_q;
    logic [7:0]    ofs_hi_q, ofs_lo_q;
    logic [7:0]    ofs_lo;
    logic [AW-1:0] pc_p1, ret, target, s_m1, s_m2;

    // Low offset byte is consumed straight off the bus when leaving StOfsL
    assign ofs_lo = (state_q == StOfsL) ? din : ofs_lo_q;

    jtkcpu_brseq_addr #(
        .AW(AW)
    ) u_addr (
        .pc      (pc_q),
        .s       (s_q),
        .is_long (is_long_q),
        .taken   (taken_q),
        .ofs_hi  (ofs_hi_q),
        .ofs_lo  (ofs_lo),
        .pc_p1   (pc_p1),
        .ret     (ret),
        .target  (target),
        .s_m1    (s_m1),
        .s_m2    (s_m2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            s_q       <= '0;
            is_long_q <= 1'b0;
            is_sub_q  <= 1'b0;
            taken_q   <= 1'b0;
            ofs_hi_q  <= 8'h00;
            ofs_lo_q  <= 8'h00;
            addr      <= '0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            dout      <= 8'h00;
            pc_out    <= '0;
            pc_we     <= 1'b0;
            s_out     <= '0;
            s_we      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (cen) begin
            pc_we <= 1'b0;
            s_we  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        pc_q      <= pc_in;
                        s_q       <= s_in;
                        is_long_q <= op_is_long(op);
                        is_sub_q  <= op_is_sub(op);
                        taken_q   <= branch | op_is_sub(op);
                        if (op_is_short(op) || op_is_long(op)) begin
                            busy    <= 1'b1;
                            rd      <= 1'b1;
                            addr    <= pc_in;
                            state_q <= op_is_long(op) ? StOfsH : StOfsL;
                        end else begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end
                    end
                end
                StOfsH: begin
                    if (mem_ok) begin
                        ofs_hi_q <= din;
                        addr     <= pc_p1;
                        state_q  <= StOfsL;
                    end
                end
                StOfsL: begin
                    if (mem_ok) begin
                        ofs_lo_q <= din;
                        rd       <= 1'b0;
                        if (is_sub_q) begin
                            wr      <= 1'b1;
                            addr    <= s_m1;
                            dout    <= ret[7:0];
                            state_q <= StPushL;
                        end else begin
                            pc_out  <= target;
                            pc_we   <= 1'b1;
                            done    <= 1'b1;
                            state_q <= StUpdate;
                        end
                    end
                end
                StPushL: begin
                    if (mem_ok) begin
                        addr    <= s_m2;
                        dout    <= ret[15:8];
                        state_q <= StPushH;
                    end
                end
                StPushH: begin
                    if (mem_ok) begin
                        wr      <= 1'b0;
                        pc_out  <= target;
                        pc_we   <= 1'b1;
                        s_out   <= s_m2;
                        s_we    <= 1'b1;
                        done    <= 1'b1;
                        state_q <= StUpdate;
                    end
                end
                StUpdate: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
